// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div with a Busy flag, plus mthi/mtlo, driving HI/LO.
// Define MDU_FLUSH_EN to add the E_Req flush input that aborts an in-flight operation.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_Start,
`ifdef MDU_FLUSH_EN
  input  logic        E_Req,
`endif
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  output logic        E_Busy,
  output logic [31:0] E_RDHI,
  output logic [31:0] E_RDLO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] count, next_count;
  logic [31:0]      hi, lo, next_hi, next_lo;
  logic [31:0]      pend_hi, pend_lo, next_pend_hi, next_pend_lo;
  logic             pend_we, next_pend_we;
  logic             flush;

`ifdef MDU_FLUSH_EN
  assign flush = E_Req;
`else
  assign flush = 1'b0;
`endif

  logic [63:0] prod_s, prod_u;
  logic        div_zero;
  logic [31:0] safe_div, a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        is_md_op, is_mult;

  assign prod_s = $signed({{32{E_RD1[31]}}, E_RD1}) * $signed({{32{E_RD2[31]}}, E_RD2});
  assign prod_u = {32'b0, E_RD1} * {32'b0, E_RD2};

  // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow corner.
  assign div_zero = (E_RD2 == 32'd0);
  assign safe_div = div_zero ? 32'd1 : E_RD2;
  assign a_mag    = E_RD1[31] ? -E_RD1 : E_RD1;
  assign b_mag    = safe_div[31] ? -safe_div : safe_div;
  assign q_mag    = a_mag / b_mag;
  assign r_mag    = a_mag % b_mag;
  assign q_s      = (E_RD1[31] ^ safe_div[31]) ? -q_mag : q_mag;
  assign r_s      = E_RD1[31] ? -r_mag : r_mag;
  assign q_u      = E_RD1 / safe_div;
  assign r_u      = E_RD1 % safe_div;

  assign is_md_op = (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU);
  assign is_mult  = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= CNT_ZERO;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
    end else begin
      state   <= next_state;
      count   <= next_count;
      hi      <= next_hi;
      lo      <= next_lo;
      pend_hi <= next_pend_hi;
      pend_lo <= next_pend_lo;
      pend_we <= next_pend_we;
    end
  end

  always_comb begin
    next_state   = state;
    next_count   = count;
    next_hi      = hi;
    next_lo      = lo;
    next_pend_hi = pend_hi;
    next_pend_lo = pend_lo;
    next_pend_we = pend_we;
    case (state)
      IDLE: begin
        if (!flush) begin
          if (E_Start && is_md_op) begin
            next_state   = BUSY;
            next_count   = is_mult ? MULT_LOAD : DIV_LOAD;
            next_pend_we = is_mult || !div_zero;
            case (E_MDUOp)
              OP_MULT:  {next_pend_hi, next_pend_lo} = prod_s;
              OP_MULTU: {next_pend_hi, next_pend_lo} = prod_u;
              OP_DIV:   {next_pend_hi, next_pend_lo} = {r_s, q_s};
              default:  {next_pend_hi, next_pend_lo} = {r_u, q_u};
            endcase
          end else if (E_MDUOp == OP_MTHI) begin
            next_hi = E_RD1;
          end else if (E_MDUOp == OP_MTLO) begin
            next_lo = E_RD1;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          next_state   = IDLE;
          next_count   = CNT_ZERO;
          next_pend_we = 1'b0;
          next_pend_hi = 32'd0;
          next_pend_lo = 32'd0;
        end else if (count <= CNT_ONE) begin
          next_state   = IDLE;
          next_count   = CNT_ZERO;
          next_pend_we = 1'b0;
          if (pend_we) begin
            next_hi = pend_hi;
            next_lo = pend_lo;
          end
        end else begin
          next_count = count - CNT_ONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign E_Busy = (state == BUSY);
  assign E_RDHI = hi;
  assign E_RDLO = lo;

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the P6 pipeline; producer of the HI/LO pair that the E-stage MD data mux reads.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage.
- Models fixed multi-cycle latency with a Busy flag that the hazard unit uses to stall later MD instructions.
- Drives the architectural HI and LO registers.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for mult/multu (must be >= 1)
DIV_CYCLES, 10, cycles Busy stays high for div/divu (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
E_MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7-15 treated as none
E_Start  input  1  one-cycle pulse, qualifies ops 1-4
E_RD1  input  32  rs operand
E_RD2  input  32  rt operand
E_Busy  output  1  operation in flight
E_RDHI  output  32  HI register
E_RDLO  output  32  LO register

Behaviour:
- Reset (async, active-high): E_Busy=0, E_RDHI=0, E_RDLO=0, counter=0, state IDLE, pending results=0. Reset asserted mid-operation aborts the operation. HI/LO do not update. Leaving reset returns to IDLE.
- States:
  - IDLE -> BUSY: E_Start=1 and E_MDUOp in 1-4 at a clock edge.
  - BUSY -> IDLE: counter reaches 1 at a clock edge.
- Accept edge (cycle t):
  - Latch results into pending HI/LO.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - E_Busy=1 from cycle t+1.
- Each BUSY edge decrements the counter. On the edge where the counter is 1:
  - Commit pending values to E_RDHI/E_RDLO.
  - E_Busy returns to 0.
- Timing: E_Busy is high for exactly N cycles (t+1 .. t+N). New HI/LO values are visible from cycle t+N+1.
- Arithmetic:
  - mult: signed 32x32 -> 64; {HI,LO} = product.
  - multu: unsigned product.
  - div: signed, truncated toward zero; LO = quotient, HI = remainder, remainder sign follows the dividend.
  - divu: unsigned quotient and remainder.
  - Divisor 0 (div/divu): the op still runs the full DIV_CYCLES with Busy high; HI/LO are left unchanged at commit.
  - div with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- mthi/mtlo:
  - Op 5 or 6 at a clock edge in IDLE writes E_RD1 to HI or LO. The result is visible the next cycle. E_Start is not required.
  - Ignored in BUSY; the hazard unit never issues them then.
- E_Start with E_MDUOp 0 or 5-15: no start.
- E_Start in BUSY: ignored, no restart.
- E_RDHI/E_RDLO are registered outputs only; there is no combinational bypass.

Optional Feature:
- Macro: MDU_FLUSH_EN.
- With the macro defined:
  - Add input port E_Req (1 bit), an exception/interrupt flush that is synchronous to clk.
  - E_Req=1 at an edge in BUSY: return to IDLE, E_Busy=0, discard pending results, HI/LO unchanged.
  - E_Req=1 in the same cycle as E_Start or mthi/mtlo: the op is not accepted and has no effect.
- Without the macro: no E_Req port; operations always complete once accepted.

Test Plan:
- mult: RD1=0xFFFFFFFF, RD2=0x00000002, Start pulse -> Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands -> after 5 Busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div: RD1=0xFFFFFFF9 (-7), RD2=2 -> Busy high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu: RD1=7, RD2=2 -> LO=3, HI=1 after 10 cycles. Then div by RD2=0 -> Busy high 10 cycles, HI/LO stay 1/3.
- mthi RD1=0x12345678, then mtlo RD1=0x9ABCDEF0 on the following cycle -> HI and LO each update one cycle after their op. A mult Start issued during BUSY is ignored (Busy length unchanged).
- Start a div, assert reset at the 4th Busy cycle -> E_Busy=0, HI=LO=0 immediately. With MDU_FLUSH_EN, E_Req in the same situation -> Busy=0, HI/LO keep their prior values.
